// File: rtl/conv3x3_psum_gen.sv
// Sequential 3x3 convolution MAC: one pixel/weight tap per cycle, emits three signed row partial sums.
// Define CONV_PSUM_BIAS_EN to add a bias port that seeds the row-0 sum at the first tap of each window.
module conv3x3_psum_gen #(
  parameter int PIX_W  = 8,
  parameter int WGT_W  = 20,
  parameter int PSUM_W = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  pixel,
  input  logic [WGT_W-1:0]  weight,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] psum0,
  output logic [PSUM_W-1:0] psum1,
  output logic [PSUM_W-1:0] psum2,
`ifdef CONV_PSUM_BIAS_EN
  input  logic [PSUM_W-1:0] bias,
`endif
  output logic [3:0]        tap_idx
);

  localparam int PROD_W = PIX_W + WGT_W + 1;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [3:0] LAST_TAP = 4'd8;

  logic [0:0]        state_q, state_d;
  logic [3:0]        tap_idx_q, tap_idx_d;
  logic [PSUM_W-1:0] psum0_q, psum0_d;
  logic [PSUM_W-1:0] psum1_q, psum1_d;
  logic [PSUM_W-1:0] psum2_q, psum2_d;

  logic              first_tap;
  logic [1:0]        row_sel;
  logic [PSUM_W-1:0] init0;
  logic [PSUM_W-1:0] base0, base1, base2;
  logic [PROD_W-1:0] pix_ext, wgt_ext, prod;
  logic [PSUM_W-1:0] prod_ext;

  // Pixel is zero-extended (unsigned), weight sign-extended; the low PROD_W bits of the product are exact.
  assign pix_ext  = {{(PROD_W-PIX_W){1'b0}}, pixel};
  assign wgt_ext  = {{(PROD_W-WGT_W){weight[WGT_W-1]}}, weight};
  assign prod     = pix_ext * wgt_ext;
  assign prod_ext = {{(PSUM_W-PROD_W){prod[PROD_W-1]}}, prod};

  assign first_tap = (tap_idx_q == 4'd0);

`ifdef CONV_PSUM_BIAS_EN
  assign init0 = bias;
`else
  assign init0 = '0;
`endif

  // Sums restart at tap 0 so nothing from the previous window can leak forward.
  assign base0 = first_tap ? init0 : psum0_q;
  assign base1 = first_tap ? '0    : psum1_q;
  assign base2 = first_tap ? '0    : psum2_q;

  always_comb begin
    if (tap_idx_q < 4'd3) begin
      row_sel = 2'd0;
    end else if (tap_idx_q < 4'd6) begin
      row_sel = 2'd1;
    end else begin
      row_sel = 2'd2;
    end
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    tap_idx_d = tap_idx_q;
    psum0_d   = psum0_q;
    psum1_d   = psum1_q;
    psum2_d   = psum2_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          psum0_d = (row_sel == 2'd0) ? base0 + prod_ext : base0;
          psum1_d = (row_sel == 2'd1) ? base1 + prod_ext : base1;
          psum2_d = (row_sel == 2'd2) ? base2 + prod_ext : base2;
          if (tap_idx_q == LAST_TAP) begin
            tap_idx_d = 4'd0;
            state_d   = ST_HOLD;
          end else begin
            tap_idx_d = tap_idx_q + 4'd1;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= ST_ACC;
      tap_idx_q <= 4'd0;
      psum0_q   <= '0;
      psum1_q   <= '0;
      psum2_q   <= '0;
    end else begin
      state_q   <= state_d;
      tap_idx_q <= tap_idx_d;
      psum0_q   <= psum0_d;
      psum1_q   <= psum1_d;
      psum2_q   <= psum2_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign tap_idx   = tap_idx_q;
  assign psum0     = psum0_q;
  assign psum1     = psum1_q;
  assign psum2     = psum2_q;

endmodule
